// File: rtl/keyboard_pkg.sv
// Scan codes and the scan-code-to-hex-digit lookup used by the PS/2 keyboard front-end.
package keyboard_pkg;

    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Returns {valid, nibble}; valid is low for codes that are not hex digits.
    function automatic logic [4:0] scan_to_nibble(input logic [7:0] sc);
        logic [4:0] r;
        case (sc)
            8'h45:   r = {1'b1, 4'h0};
            8'h16:   r = {1'b1, 4'h1};
            8'h1E:   r = {1'b1, 4'h2};
            8'h26:   r = {1'b1, 4'h3};
            8'h25:   r = {1'b1, 4'h4};
            8'h2E:   r = {1'b1, 4'h5};
            8'h36:   r = {1'b1, 4'h6};
            8'h3D:   r = {1'b1, 4'h7};
            8'h3E:   r = {1'b1, 4'h8};
            8'h46:   r = {1'b1, 4'h9};
            8'h1C:   r = {1'b1, 4'hA};
            8'h32:   r = {1'b1, 4'hB};
            8'h21:   r = {1'b1, 4'hC};
            8'h23:   r = {1'b1, 4'hD};
            8'h24:   r = {1'b1, 4'hE};
            8'h2B:   r = {1'b1, 4'hF};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/keyboard_input_if.sv
// PS/2 lines in, decoded user-input stream out; the keyboard side is master, the decoder is slave.
interface keyboard_input_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] entry_value;
    logic [1:0] digit_count;
    logic       load_signal;
    logic       start_signal;
    logic       frame_error;

    modport master (
        output ps2_clk, ps2_dat,
        input  entry_value, digit_count, load_signal, start_signal, frame_error
    );

    modport slave (
        input  ps2_clk, ps2_dat,
        output entry_value, digit_count, load_signal, start_signal, frame_error
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronisers, falling-edge sampling, framing checks, timeout.
module ps2_frame_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          clk_s1, clk_s2, clk_d;
    logic          dat_s1, dat_s2;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] idle_cnt;
    logic [8:0]    shreg;
    logic          start_bit;
    logic          fall;
    logic          timeout_hit;

    assign fall        = clk_d & ~clk_s2;
    assign timeout_hit = clk_s2 && (bit_cnt != 4'd0) && (idle_cnt == IDLE_LAST);

    // Sync flops idle high so release from reset never looks like a falling edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_s1      <= 1'b1;
            clk_s2      <= 1'b1;
            clk_d       <= 1'b1;
            dat_s1      <= 1'b1;
            dat_s2      <= 1'b1;
            bit_cnt     <= 4'd0;
            idle_cnt    <= '0;
            code_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            clk_s1      <= ps2_clk;
            clk_s2      <= clk_s1;
            clk_d       <= clk_s2;
            dat_s1      <= ps2_dat;
            dat_s2      <= dat_s1;
            code_valid  <= 1'b0;
            frame_error <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    if (!start_bit && (^shreg) && dat_s2)
                        code_valid <= 1'b1;
                    else
                        frame_error <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (timeout_hit) begin
                bit_cnt     <= 4'd0;
                idle_cnt    <= '0;
                frame_error <= 1'b1;
            end else if (clk_s2 && (bit_cnt != 4'd0)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    // Payload shifts in LSB first; after nine shifts shreg = {parity, d7..d0}.
    always_ff @(posedge clock) begin
        if (fall) begin
            if (bit_cnt == 4'd0)
                start_bit <= dat_s2;
            else if (bit_cnt <= 4'd9)
                shreg <= {dat_s2, shreg[8:1]};
            if (bit_cnt == 4'd10)
                code <= shreg[7:0];
        end
    end

endmodule

// File: rtl/keyboard_input.sv
// PS/2 keyboard decoder: two-digit hex entry plus load/start pulses toward main_control.
module keyboard_input
    import keyboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic           clock,
    input  logic           resetn,
    keyboard_input_if.slave kif
);
    logic [7:0] code;
    logic       code_valid;
    logic       rx_error;
    logic [4:0] digit;
    logic       break_flag;
    logic       ext_flag;
    logic [7:0] entry;
    logic [1:0] count;
    logic       load;
    logic       start;

    ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clock       (clock),
        .resetn      (resetn),
        .ps2_clk     (kif.ps2_clk),
        .ps2_dat     (kif.ps2_dat),
        .code        (code),
        .code_valid  (code_valid),
        .frame_error (rx_error)
    );

    assign digit = scan_to_nibble(code);

    // A prefix byte swallows exactly one following code, so released and extended keys do nothing.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            break_flag <= 1'b0;
            ext_flag   <= 1'b0;
            entry      <= 8'd0;
            count      <= 2'd0;
            load       <= 1'b0;
            start      <= 1'b0;
        end else begin
            load  <= 1'b0;
            start <= 1'b0;
            if (code_valid) begin
                if (code == SC_BREAK) begin
                    break_flag <= 1'b1;
                end else if (code == SC_EXT) begin
                    ext_flag <= 1'b1;
                end else if (break_flag || ext_flag) begin
                    break_flag <= 1'b0;
                    ext_flag   <= 1'b0;
                end else if (digit[4]) begin
                    entry <= {entry[3:0], digit[3:0]};
                    if (count != 2'd2)
                        count <= count + 2'd1;
                end else if (code == SC_ENTER) begin
                    load <= 1'b1;
                end else if (code == SC_SPACE) begin
                    start <= 1'b1;
                end else if (code == SC_BKSP) begin
                    entry <= 8'd0;
                    count <= 2'd0;
                end
            end
        end
    end

    assign kif.entry_value  = entry;
    assign kif.digit_count  = count;
    assign kif.load_signal  = load;
    assign kif.start_signal = start;
    assign kif.frame_error  = rx_error;

endmodule

// File: tb/tb_keyboard_input.sv
// Directed bench for keyboard_input: PS/2 frames driven on the pins, decoded outputs checked per scenario.
module tb_keyboard_input;
    localparam int TO = 500;
    localparam int H  = 8;

    logic clock;
    logic resetn;
    int   total;
    int   bad;
    int   n_load, n_start, n_err, n_long;
    logic [7:0] load_entry;
    logic p_load, p_start, p_err;

    keyboard_input_if kif ();

    keyboard_input #(.TIMEOUT_CYCLES(TO)) dut (
        .clock  (clock),
        .resetn (resetn),
        .kif    (kif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        n_load = 0; n_start = 0; n_err = 0; n_long = 0;
        p_load = 1'b0; p_start = 1'b0; p_err = 1'b0;
        load_entry = 8'd0;
    end

    // Pulse counters; a pulse seen on two consecutive samples counts as too long.
    always @(negedge clock) begin
        if (kif.load_signal) begin
            n_load = n_load + 1;
            load_entry = kif.entry_value;
        end
        if (kif.start_signal) n_start = n_start + 1;
        if (kif.frame_error)  n_err   = n_err + 1;
        if ((kif.load_signal && p_load) || (kif.start_signal && p_start) || (kif.frame_error && p_err))
            n_long = n_long + 1;
        p_load  = kif.load_signal;
        p_start = kif.start_signal;
        p_err   = kif.frame_error;
    end

    task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop, input int nedges);
        logic [10:0] bits;
        bits = {stop, (~^b) ^ ~par_ok, b, 1'b0};
        for (int i = 0; i < nedges; i++) begin
            kif.ps2_dat = bits[i];
            repeat (H) @(posedge clock);
            #2 kif.ps2_clk = 1'b0;
            repeat (H) @(posedge clock);
            #2 kif.ps2_clk = 1'b1;
        end
        kif.ps2_dat = 1'b1;
        repeat (20) @(posedge clock);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b1, 1'b1, 11);
    endtask

    task automatic test_reset;
        total++; if (kif.entry_value !== 8'h00) begin bad++; $display("FAIL reset_entry got=%h exp=00", kif.entry_value); end
        total++; if (kif.digit_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", kif.digit_count); end
        total++; if (kif.load_signal !== 1'b0) begin bad++; $display("FAIL reset_load got=%b exp=0", kif.load_signal); end
        total++; if (kif.start_signal !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", kif.start_signal); end
        total++; if (kif.frame_error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", kif.frame_error); end
    endtask

    task automatic test_enter;
        int l0, s0;
        l0 = n_load; s0 = n_start;
        send(8'h26);
        send(8'h1C);
        total++; if (n_load - l0 !== 0) begin bad++; $display("FAIL enter_early_load got=%0d exp=0", n_load - l0); end
        send(8'h5A);
        total++; if (kif.entry_value !== 8'h3A) begin bad++; $display("FAIL enter_entry got=%h exp=3a", kif.entry_value); end
        total++; if (kif.digit_count !== 2'd2) begin bad++; $display("FAIL enter_count got=%0d exp=2", kif.digit_count); end
        total++; if (n_load - l0 !== 1) begin bad++; $display("FAIL enter_load_pulses got=%0d exp=1", n_load - l0); end
        total++; if (load_entry !== 8'h3A) begin bad++; $display("FAIL enter_entry_at_load got=%h exp=3a", load_entry); end
        total++; if (n_start - s0 !== 0) begin bad++; $display("FAIL enter_start_pulses got=%0d exp=0", n_start - s0); end
    endtask

    task automatic test_digits_bksp;
        send(8'h16);
        send(8'h1E);
        send(8'h26);
        total++; if (kif.entry_value !== 8'h23) begin bad++; $display("FAIL shift_entry got=%h exp=23", kif.entry_value); end
        total++; if (kif.digit_count !== 2'd2) begin bad++; $display("FAIL shift_count got=%0d exp=2", kif.digit_count); end
        send(8'h66);
        total++; if (kif.entry_value !== 8'h00) begin bad++; $display("FAIL bksp_entry got=%h exp=00", kif.entry_value); end
        total++; if (kif.digit_count !== 2'd0) begin bad++; $display("FAIL bksp_count got=%0d exp=0", kif.digit_count); end
    endtask

    task automatic test_break_ext;
        int s0;
        send(8'h45);
        total++; if (kif.digit_count !== 2'd1) begin bad++; $display("FAIL zero_count got=%0d exp=1", kif.digit_count); end
        send(8'hF0);
        send(8'h45);
        total++; if (kif.entry_value !== 8'h00) begin bad++; $display("FAIL break_entry got=%h exp=00", kif.entry_value); end
        total++; if (kif.digit_count !== 2'd1) begin bad++; $display("FAIL break_count got=%0d exp=1", kif.digit_count); end
        s0 = n_start;
        send(8'hE0);
        send(8'h29);
        total++; if (n_start - s0 !== 0) begin bad++; $display("FAIL ext_space_start got=%0d exp=0", n_start - s0); end
        send(8'h29);
        total++; if (n_start - s0 !== 1) begin bad++; $display("FAIL space_start got=%0d exp=1", n_start - s0); end
        total++; if (kif.entry_value !== 8'h00) begin bad++; $display("FAIL space_entry got=%h exp=00", kif.entry_value); end
    endtask

    task automatic test_frame_errors;
        int e0;
        e0 = n_err;
        send_frame(8'h26, 1'b0, 1'b1, 11);
        total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL parity_err got=%0d exp=1", n_err - e0); end
        total++; if (kif.entry_value !== 8'h00) begin bad++; $display("FAIL parity_entry got=%h exp=00", kif.entry_value); end
        total++; if (kif.digit_count !== 2'd1) begin bad++; $display("FAIL parity_count got=%0d exp=1", kif.digit_count); end
        send_frame(8'h26, 1'b1, 1'b0, 11);
        total++; if (n_err - e0 !== 2) begin bad++; $display("FAIL stop_err got=%0d exp=2", n_err - e0); end
        total++; if (kif.entry_value !== 8'h00) begin bad++; $display("FAIL stop_entry got=%h exp=00", kif.entry_value); end
    endtask

    task automatic test_timeout;
        int e0;
        e0 = n_err;
        send_frame(8'h1C, 1'b1, 1'b1, 5);
        total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL timeout_early got=%0d exp=0", n_err - e0); end
        repeat (TO + 10) @(posedge clock);
        #2;
        total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL timeout_err got=%0d exp=1", n_err - e0); end
        send(8'h2B);
        total++; if (kif.entry_value[3:0] !== 4'hF) begin bad++; $display("FAIL timeout_nibble got=%h exp=f", kif.entry_value[3:0]); end
        total++; if (kif.entry_value !== 8'h0F) begin bad++; $display("FAIL timeout_entry got=%h exp=0f", kif.entry_value); end
        total++; if (kif.digit_count !== 2'd2) begin bad++; $display("FAIL timeout_count got=%0d exp=2", kif.digit_count); end
    endtask

    task automatic test_reset_midframe;
        int e0;
        send_frame(8'h1C, 1'b1, 1'b1, 6);
        #1 resetn = 1'b0;
        #3;
        total++; if (kif.entry_value !== 8'h00) begin bad++; $display("FAIL midrst_entry got=%h exp=00", kif.entry_value); end
        total++; if (kif.digit_count !== 2'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", kif.digit_count); end
        @(posedge clock);
        #2 resetn = 1'b1;
        e0 = n_err;
        send(8'h24);
        total++; if (kif.entry_value !== 8'h0E) begin bad++; $display("FAIL midrst_entry_after got=%h exp=0e", kif.entry_value); end
        total++; if (kif.digit_count !== 2'd1) begin bad++; $display("FAIL midrst_count_after got=%0d exp=1", kif.digit_count); end
        total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL midrst_err got=%0d exp=0", n_err - e0); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        resetn = 1'b0;
        kif.ps2_clk = 1'b1;
        kif.ps2_dat = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        test_reset;
        resetn = 1'b1;
        repeat (5) @(posedge clock);
        #2;
        test_enter;
        test_digits_bksp;
        test_break_ext;
        test_frame_errors;
        test_timeout;
        test_reset_midframe;
        total++; if (n_long !== 0) begin bad++; $display("FAIL pulse_width long_pulses=%0d exp=0", n_long); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
